// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard sequencing logic.
//   hz_state_t : hazard sequencer state (HZ_RUN, HZ_HOLD)
//   XZR_IDX    : zero-register index, never a hazard source
//   STAT_W     : width of the optional stall/flush statistics counters
package cpu_pkg;

  localparam int unsigned STAT_W  = 16;
  localparam logic [4:0]  XZR_IDX = 5'd31;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard match terms for the instruction in ID.
// Ports:
//   IFID_Rn, IFID_Rm            source register indices of the ID instruction
//   IFID_uses_Rn, IFID_uses_Rm  source-valid qualifiers
//   IFID_is_CBZ                 ID instruction is CBZ (tests IFID_Rm)
//   IDEX_Rd, EXMEM_Rd           destination registers of the younger stages
//   IDEX_MemRead, EXMEM_MemRead stage holds a load
//   ld_use                      ID source depends on the load in ID/EX
//   cbz_ld1                     CBZ operand is the load in EX/MEM (one cycle short)
//   cbz_ld2                     CBZ operand is the load in ID/EX (two cycles short)
module hazard_detect #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned XZR   = 31
) (
  input  logic [REG_W-1:0] IFID_Rn,
  input  logic [REG_W-1:0] IFID_Rm,
  input  logic             IFID_uses_Rn,
  input  logic             IFID_uses_Rm,
  input  logic             IFID_is_CBZ,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic [REG_W-1:0] EXMEM_Rd,
  input  logic             IDEX_MemRead,
  input  logic             EXMEM_MemRead,
  output logic             ld_use,
  output logic             cbz_ld1,
  output logic             cbz_ld2
);

  localparam logic [REG_W-1:0] XzrIdx = REG_W'(XZR);

  logic idex_load;
  logic exmem_load;

  // A load into the zero register produces nothing anyone can depend on.
  assign idex_load  = IDEX_MemRead  && (IDEX_Rd  != XzrIdx);
  assign exmem_load = EXMEM_MemRead && (EXMEM_Rd != XzrIdx);

  assign ld_use  = idex_load && ((IFID_uses_Rn && (IFID_Rn == IDEX_Rd)) ||
                                 (IFID_uses_Rm && (IFID_Rm == IDEX_Rd)));
  assign cbz_ld2 = IFID_is_CBZ && idex_load  && (IFID_Rm == IDEX_Rd);
  assign cbz_ld1 = IFID_is_CBZ && exmem_load && (IFID_Rm == EXMEM_Rd);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage pipeline. Detects load-use and
// CBZ-on-load hazards at the IF/ID boundary and stalls the front end until the
// needed operand is available to the CBZ forwarder (ID/EX ALU result or EX/MEM).
// Optional feature macro: HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   IFID_*                      source indices/qualifiers of the ID instruction
//   IDEX_Rd/MemRead             load destination in ID/EX
//   EXMEM_Rd/MemRead            load destination in EX/MEM
//   branch_taken                ID-stage branch resolved taken
//   PC_write, IFID_write        front-end enables (0 while stalling)
//   IDEX_bubble                 zero ID/EX control bits
//   IFID_flush                  clear IF/ID on next edge
//   stall_cnt, flush_cnt        statistics (HAZARD_STATS_EN only)
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned XZR   = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  IFID_Rn,
  input  logic [REG_W-1:0]  IFID_Rm,
  input  logic              IFID_uses_Rn,
  input  logic              IFID_uses_Rm,
  input  logic              IFID_is_CBZ,
  input  logic [REG_W-1:0]  IDEX_Rd,
  input  logic [REG_W-1:0]  EXMEM_Rd,
  input  logic              IDEX_MemRead,
  input  logic              EXMEM_MemRead,
  input  logic              branch_taken,
  output logic              PC_write,
  output logic              IFID_write,
  output logic              IDEX_bubble,
  output logic              IFID_flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  logic      ld_use;
  logic      cbz_ld1;
  logic      cbz_ld2;
  logic      stall;
  hz_state_t state_q;
  hz_state_t state_d;

  hazard_detect #(
    .REG_W (REG_W),
    .XZR   (XZR)
  ) u_detect (
    .IFID_Rn       (IFID_Rn),
    .IFID_Rm       (IFID_Rm),
    .IFID_uses_Rn  (IFID_uses_Rn),
    .IFID_uses_Rm  (IFID_uses_Rm),
    .IFID_is_CBZ   (IFID_is_CBZ),
    .IDEX_Rd       (IDEX_Rd),
    .EXMEM_Rd      (EXMEM_Rd),
    .IDEX_MemRead  (IDEX_MemRead),
    .EXMEM_MemRead (EXMEM_MemRead),
    .ld_use        (ld_use),
    .cbz_ld1       (cbz_ld1),
    .cbz_ld2       (cbz_ld2)
  );

  // Stall decision is same-cycle; only the HOLD marker is carried across edges.
  // cbz_ld2 wins over ld_use so a simultaneous match always takes two cycles.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        if (cbz_ld2) begin
          stall   = 1'b1;
          state_d = HZ_HOLD;
        end else if (ld_use || cbz_ld1) begin
          stall = 1'b1;
        end
      end
      HZ_HOLD: begin
        // Load has moved to EX/MEM; one more cycle before CBZ can forward it.
        stall   = 1'b1;
        state_d = HZ_RUN;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // During a stall the CBZ operand is not yet valid, so branch_taken is
  // meaningless and must not flush; the branch is re-evaluated on release.
  always_comb begin
    if (reset) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
      IFID_flush  = 1'b1;
    end else if (stall) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
      IFID_flush  = 1'b0;
    end else begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IDEX_bubble = 1'b0;
      IFID_flush  = branch_taken;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] CntMax = {STAT_W{1'b1}};

  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != CntMax)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (IFID_flush && (flush_cnt_q != CntMax)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized
// stimulus compared against a stall-countdown reference model.
module tb_hazard_controller;

  localparam int unsigned REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] IFID_Rn, IFID_Rm, IDEX_Rd, EXMEM_Rd;
  logic             IFID_uses_Rn, IFID_uses_Rm, IFID_is_CBZ;
  logic             IDEX_MemRead, EXMEM_MemRead, branch_taken;
  logic             PC_write, IFID_write, IDEX_bubble, IFID_flush;
`ifdef HAZARD_STATS_EN
  logic [15:0]      stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_W (REG_W),
    .XZR   (31)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .IFID_Rn       (IFID_Rn),
    .IFID_Rm       (IFID_Rm),
    .IFID_uses_Rn  (IFID_uses_Rn),
    .IFID_uses_Rm  (IFID_uses_Rm),
    .IFID_is_CBZ   (IFID_is_CBZ),
    .IDEX_Rd       (IDEX_Rd),
    .EXMEM_Rd      (EXMEM_Rd),
    .IDEX_MemRead  (IDEX_MemRead),
    .EXMEM_MemRead (EXMEM_MemRead),
    .branch_taken  (branch_taken),
    .PC_write      (PC_write),
    .IFID_write    (IFID_write),
    .IDEX_bubble   (IDEX_bubble),
    .IFID_flush    (IFID_flush)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: number of further cycles the front end must stay
  // stalled regardless of what is in ID, plus the statistics counters.
  int          stall_left = 0;
  int unsigned m_stalls   = 0;
  int unsigned m_flushes  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance.
  task automatic step(input string tag, input logic rst,
                      input logic [4:0] rn, input logic [4:0] rm,
                      input logic urn, input logic urm, input logic cbz,
                      input logic [4:0] idex_rd, input logic idex_mr,
                      input logic [4:0] exmem_rd, input logic exmem_mr,
                      input logic bt);
    bit          ld, c1, c2, stall_now, flush_now;
    logic [3:0]  exp_out;
    @(negedge clk);
    reset         = rst;
    IFID_Rn       = rn;
    IFID_Rm       = rm;
    IFID_uses_Rn  = urn;
    IFID_uses_Rm  = urm;
    IFID_is_CBZ   = cbz;
    IDEX_Rd       = idex_rd;
    IDEX_MemRead  = idex_mr;
    EXMEM_Rd      = exmem_rd;
    EXMEM_MemRead = exmem_mr;
    branch_taken  = bt;
    #1;
    ld = idex_mr && idex_rd != 5'd31 && ((urn && rn == idex_rd) || (urm && rm == idex_rd));
    c2 = cbz && idex_mr && idex_rd != 5'd31 && rm == idex_rd;
    c1 = cbz && exmem_mr && exmem_rd != 5'd31 && rm == exmem_rd;
    stall_now = !rst && (stall_left > 0 || ld || c1 || c2);
    flush_now = !rst && !stall_now && bt;
    if (rst)            exp_out = 4'b0011;
    else if (stall_now) exp_out = 4'b0010;
    else                exp_out = {2'b11, 1'b0, bt};
    check_eq(tag, {28'd0, PC_write, IFID_write, IDEX_bubble, IFID_flush}, {28'd0, exp_out});
`ifdef HAZARD_STATS_EN
    check_eq({tag, "_scnt"}, {16'd0, stall_cnt}, m_stalls);
    check_eq({tag, "_fcnt"}, {16'd0, flush_cnt}, m_flushes);
`endif
    @(posedge clk);
    if (rst) begin
      stall_left = 0;
      m_stalls   = 0;
      m_flushes  = 0;
    end else begin
      if (stall_left > 0)  stall_left = stall_left - 1;
      else if (c2)         stall_left = 1;
      if (stall_now && m_stalls  < 32'hFFFF) m_stalls++;
      if (flush_now && m_flushes < 32'hFFFF) m_flushes++;
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd2;
      1:       return 5'd3;
      2:       return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    // Reset state
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 2, 2, 1, 1, 1, 2, 1, 2, 1, 1);
    step("idle",   0, 1, 4, 1, 1, 0, 5, 0, 6, 0, 0);

    // LDUR X2 in IDEX, ADD uses X2: one stall then release
    step("lduse_stall",   0, 2, 7, 1, 1, 0, 2, 1, 0, 0, 0);
    step("lduse_release", 0, 2, 7, 1, 1, 0, 5, 0, 2, 1, 0);

    // LDUR X3 in IDEX, CBZ X3 (branch taken ignored until release)
    step("cbz2_s1",    0, 0, 3, 0, 1, 1, 3, 1, 0, 0, 1);
    step("cbz2_hold",  0, 0, 3, 0, 1, 1, 9, 0, 3, 1, 1);
    step("cbz2_flush", 0, 0, 3, 0, 1, 1, 9, 0, 8, 0, 1);

    // LDUR X3 in EXMEM, CBZ X3: exactly one stall
    step("cbz1_s1",  0, 0, 3, 0, 1, 1, 9, 0, 3, 1, 0);
    step("cbz1_rel", 0, 0, 3, 0, 1, 1, 9, 0, 4, 0, 0);

    // XZR is never a hazard source; plain taken branch flushes
    step("xzr_nostall", 0, 31, 31, 1, 1, 1, 31, 1, 31, 1, 0);
    step("bt_flush",    0, 1, 2, 1, 1, 0, 5, 0, 6, 0, 1);

    // Simultaneous ld_use and cbz_ld2 takes two cycles
    step("both_s1", 0, 4, 4, 1, 1, 1, 4, 1, 0, 0, 0);
    step("both_s2", 0, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0);
    step("both_rel", 0, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0);

    // Reset during HOLD abandons it
    step("rh_s1",    0, 0, 3, 0, 1, 1, 3, 1, 0, 0, 0);
    step("rh_reset", 1, 0, 3, 0, 1, 1, 8, 0, 3, 0, 1);
    step("rh_rel",   0, 0, 3, 0, 1, 1, 8, 0, 9, 0, 1);

`ifdef HAZARD_STATS_EN
    step("st_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("st_a", 0, 2, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    step("st_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("st_c", 0, 2, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    step("st_d", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("st_e", 0, 2, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    step("st_f", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    check_eq("flush_cnt2", {16'd0, flush_cnt}, 32'd2);
    // Hold a load-use hazard until the stall counter saturates
    for (int i = 0; i < 65540; i++) begin
      step("sat", 0, 2, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    end
    check_eq("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    step("rst_clear", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 49) == 0),
           rnd_reg(), rnd_reg(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0),
           rnd_reg(), 1'($urandom_range(0, 1)),
           rnd_reg(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
